// File: rtl/o1_seq.sv
// Exhaustive 4-input truth-table sweeper: steps a..d through all 16 vectors,
// settles each one, samples y against an expected table and records mismatches.
module o1_seq #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] exp_tt_i,
    input  logic        y_i,
    output logic        a_o,
    output logic        b_o,
    output logic        c_o,
    output logic        d_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        aborted_o,
    output logic        pass_o,
    output logic [4:0]  err_cnt_o,
    output logic [3:0]  first_fail_idx_o,
    output logic [15:0] fail_vec_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE_ST = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  ffi_q, ffi_d;
    logic [15:0] fv_q, fv_d;
    logic        pass_q, pass_d;
    logic        aborted_q, aborted_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mismatch_s;

    assign mismatch_s = y_i ^ exp_tt_i[idx_q];

    // Next-state and bookkeeping for the sweep FSM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffi_d     = ffi_q;
        fv_d      = fv_q;
        pass_d    = pass_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d     = 4'd0;
                    cnt_d     = CNT_RELOAD;
                    err_d     = 5'd0;
                    ffi_d     = 4'd0;
                    fv_d      = 16'h0000;
                    pass_d    = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = SETTLE_ST;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE_ST: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                    idx_d     = 4'd0;
                    state_d   = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                    idx_d     = 4'd0;
                    state_d   = IDLE;
                end else begin
                    if (mismatch_s) begin
                        fv_d[idx_q] = 1'b1;
                        // Saturate defensively; 16 vectors can never exceed 16 errors.
                        if (err_q != 5'd16) begin
                            err_d = err_q + 5'd1;
                        end else begin
                            err_d = err_q;
                        end
                        if (err_q == 5'd0) begin
                            ffi_d = idx_q;
                        end else begin
                            ffi_d = ffi_q;
                        end
                    end else begin
                        fv_d = fv_q;
                    end
                    if (idx_q == 4'd15) begin
                        pass_d  = (err_d == 5'd0);
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = CNT_RELOAD;
                        state_d = SETTLE_ST;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SETTLE_ST) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= 4'd0;
            err_q     <= 5'd0;
            ffi_q     <= 4'd0;
            fv_q      <= 16'h0000;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffi_q     <= ffi_d;
            fv_q      <= fv_d;
            pass_q    <= pass_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign {a_o, b_o, c_o, d_o} = idx_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign aborted_o        = aborted_q;
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_q;
    assign first_fail_idx_o = ffi_q;
    assign fail_vec_o       = fv_q;

endmodule

// File: doc/o1_seq.md
O1_SEQ -- requirements
Module: o1_seq

Interface
REQ-001 Parameter: SETTLE, 2, hold cycles per vector before sampling y; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 abort  input  1  synchronous sweep cancel; honoured only in SETTLE or SAMPLE.
REQ-006 exp_tt  input  16  expected truth table; bit i is the expected y for vector i; sampled in SAMPLE.
REQ-007 y  input  1  output of the 4-input combinational DUT under test.
REQ-008 a, b, c, d  output  1 each  registered DUT stimulus; {a,b,c,d} = idx, with a as MSB.
REQ-009 busy  output  1  high in SETTLE and SAMPLE.
REQ-010 done  output  1  one-cycle pulse on completion of a full sweep.
REQ-011 aborted  output  1  high after an aborted sweep; cleared on the next accepted start.
REQ-012 pass  output  1  high when the last completed sweep had err_cnt == 0.
REQ-013 err_cnt  output  5  number of mismatching vectors in the current or last sweep, range 0..16.
REQ-014 first_fail_idx  output  4  lowest failing vector index; meaningful only when err_cnt != 0.
REQ-015 fail_vec  output  16  bit i set when vector i mismatched.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE, with a 4-bit vector index idx and a 4-bit settle counter.
REQ-017 In IDLE with start=1, the next edge SHALL:
- set idx=0 and settle counter=SETTLE-1;
- clear err_cnt, fail_vec, first_fail_idx, pass and aborted;
- enter SETTLE.
REQ-018 In SETTLE, the counter SHALL decrement each cycle; when it is 0, the FSM SHALL go to SAMPLE on the next edge.
REQ-019 In SAMPLE, the block SHALL compare y against exp_tt[idx]. On a mismatch it SHALL:
- set fail_vec[idx];
- increment err_cnt;
- load first_fail_idx=idx if err_cnt was 0.
REQ-020 After SAMPLE with idx<15, the block SHALL increment idx, reload the counter with SETTLE-1 and return to SETTLE.
REQ-021 After SAMPLE with idx=15, the block SHALL enter DONE and set pass=(final err_cnt==0), counting the idx-15 result.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; idx SHALL hold 15 until the next start.
REQ-023 Each vector SHALL occupy exactly SETTLE+1 cycles, and done SHALL assert 16*(SETTLE+1) edges after the start-accepting edge.
REQ-024 start SHALL be ignored outside IDLE; start coinciding with the DONE cycle SHALL be ignored.
REQ-025 abort=1 in SETTLE or SAMPLE SHALL take priority over the comparison, go to IDLE, and set aborted=1 and idx=0. Partial err_cnt and fail_vec SHALL be kept, and done and pass SHALL NOT assert.
REQ-026 abort SHALL be ignored in IDLE and DONE.
REQ-027 err_cnt SHALL saturate at 16 by construction and never wrap.
REQ-028 The outputs a..d, busy and done SHALL be registered, with no combinational path from y to any output.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, idx=0, counter=0, a=b=c=d=0, busy=0, done=0, aborted=0, pass=0, err_cnt=0, first_fail_idx=0 and fail_vec=0, regardless of clock.
REQ-030 Reset asserted mid-sweep SHALL discard the sweep; no done pulse SHALL follow deassertion.
REQ-031 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-032 y=a&b&c&d model, exp_tt=16'h8000, SETTLE=2 -> done 48 cycles after start, pass=1, err_cnt=0, fail_vec=16'h0000.
REQ-033 y stuck at 0, exp_tt=16'h8000 -> pass=0, err_cnt=1, first_fail_idx=15, fail_vec=16'h8000.
REQ-034 y=a, exp_tt=16'h0000 -> err_cnt=8, first_fail_idx=8, fail_vec=16'hFF00; {a,b,c,d} steps 0000..1111, each held 3 cycles.
REQ-035 Mid-sweep checks:
- abort at idx=5 with y stuck at 1 and exp_tt=0 -> aborted=1, busy=0, err_cnt=5, fail_vec=16'h001F, no done pulse;
- start pulsed during busy -> sweep unaffected.
REQ-036 Async reset mid-sweep at idx=9 (asserted between edges) -> all outputs 0 immediately; next start runs a full, correct sweep.
REQ-037 SETTLE=1 with exp_tt matching the model -> done 32 cycles after start, pass=1.
